pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register; the next generation of the fixed-width stage latches between pipeline stages such as EX/MEM and MEM/WB.
- Carries a payload of generic width plus the writeback destination-register and regwrite fields.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush (bubble insertion), a forwarding tap and a saturating stall counter.
- Intended to replace every hand-written inter-stage register in the five-stage pipeline.

Parameters:
- DATA_W, 64: payload width in bits, e.g. readvalue and aluvalue concatenated; must be ≥1.
- RD_W, 5: destination-register index width.
- CNT_W, 16: stall counter width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- flush  input  1  synchronous flush; discards all held and incoming entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_rd  input  RD_W  upstream destination register.
- in_regwrite  input  1  upstream regwrite control.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_data  output  DATA_W  payload of the head entry.
- out_rd  output  RD_W  destination register of the head entry.
- out_regwrite  output  1  regwrite of the head entry; forced 0 when out_valid=0.
- fwd_valid  output  1  out_valid & out_regwrite & (out_rd != 0); hazard/forwarding tap.
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- State: main entry (main_v, fields) drives the out_* ports; skid entry (skid_v, fields).
- Transfer definitions: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- in_ready = ~skid_v & ~reset. It depends only on registered state, with no combinational path from out_ready.
- Reset: while reset=1, at each edge main_v=0, skid_v=0, stall_cnt=0. Held data fields are don't-care but are cleared to 0 for deterministic sim. Outputs during and after reset: out_valid=0, out_regwrite=0, fwd_valid=0, in_ready=0 during reset and 1 on the first cycle after. Reset dominates flush and all transfers, including reset arriving mid-stall with the skid full.
- Flush (reset=0, flush=1): at the edge main_v=0 and skid_v=0. A same-cycle in_xfer is discarded. A same-cycle out_xfer is counted as consumed by downstream. stall_cnt is unaffected.
- Normal update (reset=0, flush=0), evaluated in priority order:
  - main_v=0: on in_xfer, main <= input and main_v=1. Latency is 1 cycle from in_xfer to out_valid.
  - main_v=1, out_xfer, skid_v=1: main <= skid, skid_v=0. in_ready is 0 this cycle, so there is no input.
  - main_v=1, out_xfer, skid_v=0: on in_xfer, main <= input; otherwise main_v=0. This gives back-to-back throughput of 1 entry per cycle.
  - main_v=1, no out_xfer, skid_v=0: on in_xfer, skid <= input and skid_v=1. in_ready drops the next cycle.
  - main_v=1, no out_xfer, skid_v=1: hold.
- Ordering is strictly FIFO. There is no drop and no duplication; each accepted entry is emitted exactly once unless flushed.
- Data stability: while out_valid=1 and out_ready=0, out_data, out_rd and out_regwrite hold constant.
- stall_cnt: increments by 1 on each edge where out_valid=1 and out_ready=0 (reset=0). It saturates at 2^CNT_W−1 and does not wrap.
- No combinational path from in_* to out_*.

Test Plan:
- Reset then stream: reset 2 cycles, then in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 → in_ready=1 throughout; out_data=1..4 on cycles 1..4 after the first accept; stall_cnt=0.
- Back-pressure and skid: send A=0xAA, B=0xBB, C=0xCC with out_ready=0 from the cycle A appears → A held on out; B taken into skid; in_ready=0 next cycle, so C waits. Raise out_ready → A, B, C emitted in order; stall_cnt equals the number of stalled cycles.
- Flush with full skid: main=0x11 and skid=0x22, flush=1 with in_valid=1 carrying 0x33 → next cycle out_valid=0 and in_ready=1; 0x11, 0x22 and 0x33 never appear.
- Forwarding tap: entry with rd=7, regwrite=1 → fwd_valid=1. Entry with rd=0, regwrite=1 → fwd_valid=0. Entry with rd=9, regwrite=0 → fwd_valid=0.
- Saturation and mid-stall reset: CNT_W=3, hold out_ready=0 for 10 cycles → stall_cnt sticks at 7. Then reset=1 for 1 cycle → stall_cnt=0, out_valid=0, skid emptied.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer.
// The main entry drives the outputs. The skid entry catches the one extra
// entry that arrives in the cycle before back-pressure becomes visible
// upstream. Because in_ready depends only on registered state, there is
// never a combinational path from out_ready back to in_ready.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [RD_W-1:0]   main_rd;
  logic              main_regwrite;

  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;
  logic              skid_regwrite;

  logic in_xfer;
  logic out_xfer;
  logic stalled;

  // Handshake decode: readiness comes from registered state only, and the
  // stall condition is a presented entry that downstream refuses.
  always_comb begin
    in_ready = ~skid_v & ~reset;
    in_xfer  = in_valid & in_ready;
    out_xfer = main_v & out_ready;
    stalled  = main_v & ~out_ready;
  end

  // The head entry drives the outputs; regwrite is masked when no entry is
  // present, so that a stale field can never cause a writeback or forward.
  always_comb begin
    out_valid    = main_v;
    out_data     = main_data;
    out_rd       = main_rd;
    out_regwrite = main_v & main_regwrite;
    fwd_valid    = main_v & main_regwrite & (main_rd != '0);
  end

  // Main and skid entries: reset beats flush, and flush beats every transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v        <= 1'b0;
      main_data     <= '0;
      main_rd       <= '0;
      main_regwrite <= 1'b0;
      skid_v        <= 1'b0;
      skid_data     <= '0;
      skid_rd       <= '0;
      skid_regwrite <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (in_xfer) begin
        main_v        <= 1'b1;
        main_data     <= in_data;
        main_rd       <= in_rd;
        main_regwrite <= in_regwrite;
      end
    end else if (out_xfer) begin
      if (skid_v) begin
        main_data     <= skid_data;
        main_rd       <= skid_rd;
        main_regwrite <= skid_regwrite;
        skid_v        <= 1'b0;
      end else if (in_xfer) begin
        main_data     <= in_data;
        main_rd       <= in_rd;
        main_regwrite <= in_regwrite;
      end else begin
        main_v <= 1'b0;
      end
    end else if (!skid_v && in_xfer) begin
      skid_v        <= 1'b1;
      skid_data     <= in_data;
      skid_rd       <= in_rd;
      skid_regwrite <= in_regwrite;
    end
  end

  // Saturating count of back-pressured cycles. Flush does not clear it,
  // because it measures downstream stalls and not pipeline contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. A queue models the stage
// contents. Entries are pushed when the model accepts them, and the head is
// compared against the outputs every cycle until it is consumed.
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              rw;
  } entry_t;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_regwrite;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_regwrite;
  logic              fwd_valid;
  logic [CNT_W-1:0]  stall_cnt;

  entry_t     sbQueue[$];
  int         expCnt;
  bit         primed;
  int         checks;
  int         errors;
  logic       acc;

  pipe_stage_skid #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_rd(in_rd),
    .in_regwrite(in_regwrite),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_rd(out_rd),
    .out_regwrite(out_regwrite),
    .fwd_valid(fwd_valid),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the negedge, compare against the model
  // mid-cycle, update the model, then advance past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic [RD_W-1:0] rd, input logic rw,
                               input logic ordy, input logic fl,
                               input logic rst, output logic accepted);
    int     n;
    entry_t head;
    entry_t e;
    in_valid    = v;
    in_data     = d;
    in_rd       = rd;
    in_regwrite = rw;
    out_ready   = ordy;
    flush       = fl;
    reset       = rst;
    #1;
    accepted = 1'b0;
    n = sbQueue.size();
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!rst && n < 2)});
    if (primed) begin
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (n != 0)});
      checkOutput("stall_cnt", {29'd0, stall_cnt}, expCnt);
      if (n != 0) begin
        head = sbQueue[0];
        checkOutput("out_data", {16'd0, out_data}, {16'd0, head.data});
        checkOutput("out_rd", {27'd0, out_rd}, {27'd0, head.rd});
        checkOutput("out_regwrite", {31'd0, out_regwrite}, {31'd0, head.rw});
        checkOutput("fwd_valid", {31'd0, fwd_valid},
                    {31'd0, (head.rw && head.rd != 0)});
      end else begin
        checkOutput("idle_regwrite", {31'd0, out_regwrite}, 32'd0);
        checkOutput("idle_fwd", {31'd0, fwd_valid}, 32'd0);
      end
    end
    if (rst) begin
      sbQueue.delete();
      expCnt = 0;
      primed = 1'b1;
    end else begin
      if (n != 0 && !ordy && expCnt != 7) expCnt++;
      if (n != 0 && ordy) head = sbQueue.pop_front();
      if (fl) begin
        sbQueue.delete();
      end else if (v && n < 2) begin
        e.data = d;
        e.rd   = rd;
        e.rw   = rw;
        sbQueue.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int count, input logic ordy);
    logic a;
    for (int i = 0; i < count; i++) applyStimulus(1'b0, '0, '0, 1'b0, ordy, 1'b0, 1'b0, a);
  endtask

  // Empty the stage with downstream ready, within a bounded number of cycles.
  task automatic drain(input string tag);
    logic a;
    for (int i = 0; i < 8 && sbQueue.size() != 0; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, a);
    checkOutput(tag, sbQueue.size(), 32'd0);
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    expCnt = 0;
    primed = 1'b0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_rd = '0; in_regwrite = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Reset for two cycles, then stream 1..4 at full throughput.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      checkOutput("stream_accept", {31'd0, acc}, 32'd1);
    end
    drain("stream_drain");
    checkOutput("stream_stall", {29'd0, stall_cnt}, 32'd0);

    // Back-pressure: A goes to main, B goes into skid, and C waits.
    applyStimulus(1'b1, 16'h00AA, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 16'h00BB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("skid_take_b", {31'd0, acc}, 32'd1);
    checkOutput("skid_full_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 16'h00CC, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("c_waits", {31'd0, acc}, 32'd0);
    applyStimulus(1'b1, 16'h00CC, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("bp_stall_cnt", {29'd0, stall_cnt}, 32'd3);
    acc = 1'b0;
    for (int k = 0; k < 6 && !acc; k++)
      applyStimulus(1'b1, 16'h00CC, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("c_accept", {31'd0, acc}, 32'd1);
    drain("bp_drain");

    // Flush with main and skid both full and a new entry offered.
    applyStimulus(1'b1, 16'h0011, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 16'h0022, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 16'h0033, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
    idleCycles(3, 1'b1);

    // Forwarding tap across register-index and regwrite combinations.
    applyStimulus(1'b1, 16'h0101, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("fwd_rd7", {31'd0, fwd_valid}, 32'd1);
    applyStimulus(1'b1, 16'h0202, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("fwd_rd0", {31'd0, fwd_valid}, 32'd0);
    applyStimulus(1'b1, 16'h0303, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("fwd_norw", {31'd0, fwd_valid}, 32'd0);
    drain("fwd_drain");

    // Saturation, followed by a reset that arrives mid-stall with the skid full.
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 16'h0A0A, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 16'h0B0B, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    idleCycles(9, 1'b0);
    checkOutput("sat_cnt", {29'd0, stall_cnt}, 32'd7);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    reset = 1'b0;
    #1;
    checkOutput("rst_cnt", {29'd0, stall_cnt}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idleCycles(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
